// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and MDU sequencing control
// for the 5-stage MIPS pipeline.
module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES    = 4,
  parameter int unsigned DIV_CYCLES     = 32,
  parameter int unsigned CNT_W          = 6,
  parameter logic [31:0] STALL_CNT_INIT = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic        uses_rt_D,
  input  logic        branch_D,
  input  logic        jump_D,
  input  logic        pcsrc_D,
  input  logic        mfhilo_D,
  input  logic        mdu_op_D,
  input  logic [4:0]  rs_E,
  input  logic [4:0]  rt_E,
  input  logic [4:0]  writereg_E,
  input  logic [4:0]  writereg_M,
  input  logic [4:0]  writereg_W,
  input  logic        regwrite_E,
  input  logic        regwrite_M,
  input  logic        regwrite_W,
  input  logic        memtoreg_E,
  input  logic        memtoreg_M,
  input  logic        mdu_start_E,
  input  logic        mdu_div_E,
  output logic        stall_F,
  output logic        stall_D,
  output logic        flush_D,
  output logic        flush_E,
  output logic        fwd_a_D,
  output logic        fwd_b_D,
  output logic [1:0]  fwd_a_E,
  output logic [1:0]  fwd_b_E,
  output logic        mdu_busy,
  output logic        hilo_we,
  output logic [31:0] stall_cnt
);

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  typedef enum logic {
    MDU_IDLE,
    MDU_BUSY
  } mdu_state_e;

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             hilo_we_q;
  logic [31:0]      stall_cnt_q;

  logic lw_stall;
  logic br_stall;
  logic mdu_stall;
  logic stall;
  logic start_ok;

  function automatic logic hit(
    input logic [4:0] w,
    input logic [4:0] s
  );
    return (w != 5'd0) && (w == s);
  endfunction

  // Execute-stage operand select, M result beats W result
  always_comb begin
    fwd_a_E = 2'b00;
    fwd_b_E = 2'b00;
    if (regwrite_M && hit(writereg_M, rs_E))
      fwd_a_E = 2'b10;
    else if (regwrite_W && hit(writereg_W, rs_E))
      fwd_a_E = 2'b01;
    if (regwrite_M && hit(writereg_M, rt_E))
      fwd_b_E = 2'b10;
    else if (regwrite_W && hit(writereg_W, rt_E))
      fwd_b_E = 2'b01;
  end

  assign fwd_a_D = regwrite_M & hit(writereg_M, rs_D);
  assign fwd_b_D = regwrite_M & hit(writereg_M, rt_D);

  assign lw_stall = memtoreg_E & regwrite_E &
                    (hit(writereg_E, rs_D) |
                     (uses_rt_D & hit(writereg_E, rt_D)));

  assign br_stall = branch_D &
                    ((regwrite_E &
                      (hit(writereg_E, rs_D) |
                       hit(writereg_E, rt_D))) |
                     (memtoreg_M &
                      (hit(writereg_M, rs_D) |
                       hit(writereg_M, rt_D))));

  assign mdu_busy  = (cnt_q != '0);
  assign mdu_stall = (mfhilo_D | mdu_op_D) &
                     (mdu_busy | mdu_start_E);

  assign stall   = lw_stall | br_stall | mdu_stall;
  assign stall_F = stall;
  assign stall_D = stall;
  assign flush_E = stall;
  assign flush_D = (pcsrc_D | jump_D) & ~stall;

  // The bubble a start forces on its own HI/LO reader
  // in decode must not cancel that very start.
  assign start_ok = mdu_start_E & ~(lw_stall | br_stall);

  assign hilo_we   = hilo_we_q;
  assign stall_cnt = stall_cnt_q;

  // MDU busy sequencer: load latency, count down, pulse hilo_we
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      hilo_we_q <= 1'b0;
    end else begin
      hilo_we_q <= 1'b0;
      unique case (state_q)
        MDU_IDLE: begin
          if (start_ok) begin
            cnt_q   <= mdu_div_E ? DIV_N : MULT_N;
            state_q <= MDU_BUSY;
          end
        end
        MDU_BUSY: begin
          cnt_q <= cnt_q - ONE;
          if (cnt_q == ONE) begin
            state_q   <= MDU_IDLE;
            hilo_we_q <= 1'b1;
          end
        end
        default: begin
          state_q <= MDU_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Saturating count of stalled decode cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt_q <= STALL_CNT_INIT;
    else if (stall && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed cases, then random
// traffic against a time-based reference model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_D, rt_D, rs_E, rt_E;
  logic [4:0]  writereg_E, writereg_M, writereg_W;
  logic        uses_rt_D, branch_D, jump_D, pcsrc_D;
  logic        mfhilo_D, mdu_op_D;
  logic        regwrite_E, regwrite_M, regwrite_W;
  logic        memtoreg_E, memtoreg_M;
  logic        mdu_start_E, mdu_div_E;

  logic        stall_F, stall_D, flush_D, flush_E;
  logic        fwd_a_D, fwd_b_D, mdu_busy, hilo_we;
  logic [1:0]  fwd_a_E, fwd_b_E;
  logic [31:0] stall_cnt;

  logic        u_stall_F, u_stall_D, u_flush_D, u_flush_E;
  logic        u_fwd_a_D, u_fwd_b_D, u_mdu_busy, u_hilo_we;
  logic [1:0]  u_fwd_a_E, u_fwd_b_E;
  logic [31:0] u_stall_cnt;

  localparam logic [31:0] PRE = 32'hFFFF_FFF0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .uses_rt_D(uses_rt_D),
    .branch_D(branch_D), .jump_D(jump_D),
    .pcsrc_D(pcsrc_D), .mfhilo_D(mfhilo_D),
    .mdu_op_D(mdu_op_D), .rs_E(rs_E), .rt_E(rt_E),
    .writereg_E(writereg_E), .writereg_M(writereg_M),
    .writereg_W(writereg_W), .regwrite_E(regwrite_E),
    .regwrite_M(regwrite_M), .regwrite_W(regwrite_W),
    .memtoreg_E(memtoreg_E), .memtoreg_M(memtoreg_M),
    .mdu_start_E(mdu_start_E), .mdu_div_E(mdu_div_E),
    .stall_F(stall_F), .stall_D(stall_D),
    .flush_D(flush_D), .flush_E(flush_E),
    .fwd_a_D(fwd_a_D), .fwd_b_D(fwd_b_D),
    .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E),
    .mdu_busy(mdu_busy), .hilo_we(hilo_we),
    .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.STALL_CNT_INIT(PRE)) dut_sat (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .uses_rt_D(uses_rt_D),
    .branch_D(branch_D), .jump_D(jump_D),
    .pcsrc_D(pcsrc_D), .mfhilo_D(mfhilo_D),
    .mdu_op_D(mdu_op_D), .rs_E(rs_E), .rt_E(rt_E),
    .writereg_E(writereg_E), .writereg_M(writereg_M),
    .writereg_W(writereg_W), .regwrite_E(regwrite_E),
    .regwrite_M(regwrite_M), .regwrite_W(regwrite_W),
    .memtoreg_E(memtoreg_E), .memtoreg_M(memtoreg_M),
    .mdu_start_E(mdu_start_E), .mdu_div_E(mdu_div_E),
    .stall_F(u_stall_F), .stall_D(u_stall_D),
    .flush_D(u_flush_D), .flush_E(u_flush_E),
    .fwd_a_D(u_fwd_a_D), .fwd_b_D(u_fwd_b_D),
    .fwd_a_E(u_fwd_a_E), .fwd_b_E(u_fwd_b_E),
    .mdu_busy(u_mdu_busy), .hilo_we(u_hilo_we),
    .stall_cnt(u_stall_cnt)
  );

  int     n_cmp = 0;
  int     n_err = 0;
  longint cyc = 0;
  longint done_at = -1;
  longint nst = 0;

  logic       e_stall, e_flush_D, e_acc, e_busy, e_hilo;
  logic       e_fa_D, e_fb_D;
  logic [1:0] e_fa_E, e_fb_E;
  longint     e_cnt0, e_cnt1;

  function automatic logic m(input logic [4:0] w,
                             input logic [4:0] s);
    return (w != 5'd0) && (w == s);
  endfunction

  function automatic logic [1:0] fsel(input logic [4:0] s);
    if (regwrite_M && m(writereg_M, s)) return 2'b10;
    if (regwrite_W && m(writereg_W, s)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic longint sat(input longint v);
    return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Model: MDU tracked as the cycle its result lands.
  task automatic check_now();
    logic lw, br, md;
    #1;
    if (!reset) begin
      done_at = -1;
      nst = 0;
    end
    lw = memtoreg_E & regwrite_E &
         (m(writereg_E, rs_D) | (uses_rt_D & m(writereg_E, rt_D)));
    br = branch_D &
         ((regwrite_E & (m(writereg_E, rs_D) | m(writereg_E, rt_D))) |
          (memtoreg_M & (m(writereg_M, rs_D) | m(writereg_M, rt_D))));
    e_busy = (done_at >= 0) && (cyc < done_at);
    e_hilo = (done_at >= 0) && (cyc == done_at);
    md = (mfhilo_D | mdu_op_D) & (e_busy | mdu_start_E);
    e_stall = lw | br | md;
    e_flush_D = (pcsrc_D | jump_D) & ~e_stall;
    e_acc = mdu_start_E & ~e_busy & ~(lw | br);
    e_fa_E = fsel(rs_E);
    e_fb_E = fsel(rt_E);
    e_fa_D = regwrite_M & m(writereg_M, rs_D);
    e_fb_D = regwrite_M & m(writereg_M, rt_D);
    e_cnt0 = sat(nst);
    e_cnt1 = sat(longint'(PRE) + nst);
    chk("stall_F", stall_F, e_stall);
    chk("stall_D", stall_D, e_stall);
    chk("flush_E", flush_E, e_stall);
    chk("flush_D", flush_D, e_flush_D);
    chk("fwd_a_E", fwd_a_E, e_fa_E);
    chk("fwd_b_E", fwd_b_E, e_fb_E);
    chk("fwd_a_D", fwd_a_D, e_fa_D);
    chk("fwd_b_D", fwd_b_D, e_fb_D);
    chk("mdu_busy", mdu_busy, e_busy);
    chk("hilo_we", hilo_we, e_hilo);
    chk("stall_cnt", stall_cnt, e_cnt0);
    chk("stall_cnt_sat", u_stall_cnt, e_cnt1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      if (e_acc)
        done_at = cyc + (mdu_div_E ? 32 : 4) + 1;
      if (e_stall)
        nst++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic clr();
    rs_D = 0; rt_D = 0; rs_E = 0; rt_E = 0;
    writereg_E = 0; writereg_M = 0; writereg_W = 0;
    uses_rt_D = 0; branch_D = 0; jump_D = 0; pcsrc_D = 0;
    mfhilo_D = 0; mdu_op_D = 0;
    regwrite_E = 0; regwrite_M = 0; regwrite_W = 0;
    memtoreg_E = 0; memtoreg_M = 0;
    mdu_start_E = 0; mdu_div_E = 0;
  endtask

  task automatic rnd();
    rs_D = 5'($urandom_range(0, 3));
    rt_D = 5'($urandom_range(0, 3));
    rs_E = 5'($urandom_range(0, 3));
    rt_E = 5'($urandom_range(0, 3));
    writereg_E = 5'($urandom_range(0, 3));
    writereg_M = 5'($urandom_range(0, 3));
    writereg_W = 5'($urandom_range(0, 3));
    uses_rt_D = 1'($urandom);
    branch_D = ($urandom_range(0, 3) == 0);
    jump_D = ($urandom_range(0, 5) == 0);
    pcsrc_D = 1'($urandom);
    mfhilo_D = ($urandom_range(0, 5) == 0);
    mdu_op_D = ($urandom_range(0, 7) == 0);
    regwrite_E = 1'($urandom);
    regwrite_M = 1'($urandom);
    regwrite_W = 1'($urandom);
    memtoreg_E = ($urandom_range(0, 3) == 0);
    memtoreg_M = ($urandom_range(0, 3) == 0);
    mdu_start_E = ($urandom_range(0, 9) == 0);
    mdu_div_E = ($urandom_range(0, 3) == 0);
    reset = ($urandom_range(0, 149) != 0);
  endtask

  initial begin
    reset = 1'b0;
    clr();
    @(negedge clk);
    check_now();
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_busy", mdu_busy, 0);
    chk("rst_hilo", hilo_we, 0);
    tick();
    reset = 1'b1;

    regwrite_M = 1; writereg_M = 5;
    regwrite_W = 1; writereg_W = 5; rs_E = 5;
    check_now();
    chk("fwd_M", fwd_a_E, 2'b10);
    tick();
    regwrite_M = 0;
    check_now();
    chk("fwd_W", fwd_a_E, 2'b01);
    tick();
    regwrite_M = 1; writereg_M = 0; writereg_W = 0; rs_E = 0;
    check_now();
    chk("fwd_r0", fwd_a_E, 2'b00);
    tick();
    clr();

    memtoreg_E = 1; regwrite_E = 1; writereg_E = 8;
    rt_D = 8; uses_rt_D = 1;
    check_now();
    chk("lu_stall", stall_D, 1);
    chk("lu_flushE", flush_E, 1);
    tick();
    uses_rt_D = 0;
    check_now();
    chk("lu_nort", stall_D, 0);
    chk("lu_cnt", stall_cnt, 1);
    tick();
    clr();

    branch_D = 1; rs_D = 3; regwrite_E = 1;
    writereg_E = 3; pcsrc_D = 1;
    check_now();
    chk("br_stall", stall_D, 1);
    chk("br_noflush", flush_D, 0);
    tick();
    regwrite_E = 0;
    check_now();
    chk("br_flush", flush_D, 1);
    chk("br_cnt", stall_cnt, 2);
    tick();
    clr();

    mdu_start_E = 1; mfhilo_D = 1;
    for (int i = 0; i <= 5; i++) begin
      check_now();
      chk("mul_stall", stall_D, i <= 4);
      chk("mul_busy", mdu_busy, (i >= 1) && (i <= 4));
      chk("mul_hilo", hilo_we, i == 5);
      tick();
      mdu_start_E = 0;
    end
    clr();
    check_now();
    chk("mul_cnt", stall_cnt, 7);
    tick();

    mdu_start_E = 1; mdu_div_E = 1;
    check_now();
    tick();
    clr();
    for (int i = 1; i <= 9; i++) begin
      check_now();
      chk("div_busy", mdu_busy, 1);
      tick();
    end
    reset = 1'b0;
    check_now();
    chk("div_rst_busy", mdu_busy, 0);
    chk("div_rst_cnt", stall_cnt, 0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      check_now();
      chk("div_nohilo", hilo_we, 0);
      tick();
    end
    mdu_start_E = 1;
    for (int i = 0; i <= 5; i++) begin
      check_now();
      chk("mul2_hilo", hilo_we, i == 5);
      tick();
      mdu_start_E = 0;
    end

    reset = 1'b0;
    check_now();
    tick();
    reset = 1'b1;
    memtoreg_E = 1; regwrite_E = 1; writereg_E = 8; rs_D = 8;
    repeat (20) begin
      check_now();
      tick();
    end
    clr();
    check_now();
    chk("sat_cnt0", stall_cnt, 20);
    chk("sat_cnt1", u_stall_cnt, 32'hFFFF_FFFF);
    tick();

    for (int i = 0; i < 3000; i++) begin
      rnd();
      check_now();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_err);
    $finish;
  end

endmodule
